// File: rtl/cmd_server_pkg.sv
// Shared constants, FSM encoding and the decoded command type for the
// UART command frame receiver.
package cmd_server_pkg;

    localparam logic [7:0] HDR_WR_DEF = 8'h5A;
    localparam logic [7:0] HDR_RD_DEF = 8'h5B;

    // Frame = header + 8 payload bytes + trailer.
    localparam int FRAME_LEN   = 10;
    localparam int PAYLOAD_LEN = 8;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_TRAIL   = 2'd2;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // The trailer is the bitwise complement of the header that opened the frame.
    function automatic logic [7:0] trailer_of(input logic [7:0] hdr);
        return ~hdr;
    endfunction

endpackage

// File: rtl/cmd_rx_timer.sv
// Inter-byte timeout: rising-edge detect on the 2 kHz pulse plus a
// saturating tick counter. The counter is held at zero while disabled
// and cleared by every received byte; a clear wins over a coincident tick.
module cmd_rx_timer
    import cmd_server_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 4,
    parameter int TO_W          = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic            pulse_q;
    logic            tick;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Previous value starts at 0 so an edge right after reset still counts.
    assign tick = pulse & ~pulse_q;

    // Counter next-state and the expire pulse on the tick that reaches the limit.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                expire = 1'b1;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Edge-detect flop and counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_frame_rx.sv
// UART command frame receiver: hunts for 10-byte frames (hdr, addr[4],
// data[4], ~hdr), enforces an inter-byte timeout and presents one decoded
// command over a valid/ready handshake. A good frame arriving while the
// output is held and not being accepted is dropped with ERR_OVERRUN.
//
//  state   | meaning
//  HUNT    | idle, waiting for HDR_WR or HDR_RD; other bytes discarded
//  PAYLOAD | shifting in the 8 address/data bytes
//  TRAIL   | waiting for the trailer byte (~hdr)
module cmd_frame_rx
    import cmd_server_pkg::*;
#(
    parameter logic [7:0] HDR_WR        = HDR_WR_DEF,
    parameter logic [7:0] HDR_RD        = HDR_RD_DEF,
    parameter int         TIMEOUT_TICKS = 4,
    parameter int         TO_W          = 3
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST_N,
    input  logic        PULSE_2KHZ,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic        CMD_RD,
    output logic [31:0] CMD_ADDR,
    output logic [31:0] CMD_WDATA,
    output logic        ERR_FRAME,
    output logic        ERR_TIMEOUT,
    output logic        ERR_OVERRUN,
    output logic        BUSY
);

    logic [1:0]  state_q, state_d;
    logic        rd_q, rd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] shift_q, shift_d;
    logic        valid_q, valid_d;
    cmd_t        cmd_q, cmd_d;
    logic        err_frame_q, err_frame_d;
    logic        err_to_q, err_to_d;
    logic        err_ovr_q, err_ovr_d;

    logic        expire;
    logic        good_frame;
    logic        load;
    logic [7:0]  trl_exp;

    cmd_rx_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS),
        .TO_W          (TO_W)
    ) u_timer (
        .clk    (SYS_CLK),
        .rst_n  (SYS_RST_N),
        .pulse  (PULSE_2KHZ),
        .clr    (RX_VALID),
        .en     (state_q != ST_HUNT),
        .expire (expire)
    );

    assign trl_exp = trailer_of(rd_q ? HDR_RD : HDR_WR);

    // Frame parser: header hunt, payload shift, trailer check and timeout abort.
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        good_frame  = 1'b0;
        err_frame_d = 1'b0;
        err_to_d    = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (RX_VALID) begin
                    if (RX_DATA == HDR_WR) begin
                        rd_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else if (RX_DATA == HDR_RD) begin
                        rd_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (RX_VALID) begin
                    shift_d = {shift_q[55:0], RX_DATA};
                    if (cnt_q == 3'(PAYLOAD_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_TRAIL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (expire) begin
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                    state_d  = ST_HUNT;
                end
            end
            ST_TRAIL: begin
                if (RX_VALID) begin
                    if (RX_DATA == trl_exp) begin
                        good_frame = 1'b1;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                    state_d = ST_HUNT;
                end else if (expire) begin
                    err_to_d = 1'b1;
                    state_d  = ST_HUNT;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_HUNT;
            end
        endcase
    end

    // Output holding register: load when empty or being drained this cycle.
    always_comb begin
        load      = good_frame && (!valid_q || CMD_READY);
        cmd_d     = cmd_q;
        valid_d   = valid_q;
        err_ovr_d = good_frame && valid_q && !CMD_READY;
        if (load) begin
            cmd_d   = '{rd: rd_q, addr: shift_q[63:32], wdata: shift_q[31:0]};
            valid_d = 1'b1;
        end else if (CMD_READY) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q     <= ST_HUNT;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            valid_q     <= 1'b0;
            cmd_q       <= '0;
            err_frame_q <= 1'b0;
            err_to_q    <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            valid_q     <= valid_d;
            cmd_q       <= cmd_d;
            err_frame_q <= err_frame_d;
            err_to_q    <= err_to_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    assign CMD_VALID   = valid_q;
    assign CMD_RD      = cmd_q.rd;
    assign CMD_ADDR    = cmd_q.addr;
    assign CMD_WDATA   = cmd_q.wdata;
    assign ERR_FRAME   = err_frame_q;
    assign ERR_TIMEOUT = err_to_q;
    assign ERR_OVERRUN = err_ovr_q;
    assign BUSY        = (state_q != ST_HUNT);

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Scoreboard bench for cmd_frame_rx: the stimulus pushes expected commands,
// a negedge monitor pops and compares on every accepted command and counts
// error pulses, which are compared against expected counts at checkpoints.
module tb_cmd_frame_rx;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N;
    logic        PULSE_2KHZ;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_RD;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        ERR_FRAME;
    logic        ERR_TIMEOUT;
    logic        ERR_OVERRUN;
    logic        BUSY;

    cmd_frame_rx dut (
        .SYS_CLK     (SYS_CLK),
        .SYS_RST_N   (SYS_RST_N),
        .PULSE_2KHZ  (PULSE_2KHZ),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_RD      (CMD_RD),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .ERR_FRAME   (ERR_FRAME),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_OVERRUN (ERR_OVERRUN),
        .BUSY        (BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_frame = 0, n_to = 0, n_ovr = 0;
    int   e_frame = 0, e_to = 0, e_ovr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pop/compare on each handshake, count error pulses.
    always @(negedge SYS_CLK) begin : monitor
        exp_t e;
        if (SYS_RST_N === 1'b1) begin
            if (ERR_FRAME)   n_frame++;
            if (ERR_TIMEOUT) n_to++;
            if (ERR_OVERRUN) n_ovr++;
            if (CMD_VALID && CMD_READY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: got rd=%0b addr=%0h wdata=%0h, none expected",
                             CMD_RD, CMD_ADDR, CMD_WDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_rd", 64'(CMD_RD), 64'(e.rd));
                    chk("cmd_addr", 64'(CMD_ADDR), 64'(e.addr));
                    chk("cmd_wdata", 64'(CMD_WDATA), 64'(e.wdata));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit tk = 1'b0);
        @(posedge SYS_CLK); #1;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        if (tk) PULSE_2KHZ = 1'b1;
        @(posedge SYS_CLK); #1;
        RX_VALID   = 1'b0;
        PULSE_2KHZ = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] trl,
                              input bit tk = 1'b0);
        send_byte(hdr, tk);
        for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8], tk);
        for (int i = 3; i >= 0; i--) send_byte(wdata[i*8 +: 8], tk);
        send_byte(trl, tk);
    endtask

    task automatic do_tick();
        @(posedge SYS_CLK); #1;
        PULSE_2KHZ = 1'b1;
        repeat (2) @(posedge SYS_CLK);
        #1;
        PULSE_2KHZ = 1'b0;
        repeat (2) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_err_frame"},   64'(n_frame), 64'(e_frame));
        chk({tag, "_err_timeout"}, 64'(n_to),    64'(e_to));
        chk({tag, "_err_overrun"}, 64'(n_ovr),   64'(e_ovr));
        chk({tag, "_sb_drained"},  64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        SYS_RST_N  = 1'b0;
        PULSE_2KHZ = 1'b0;
        RX_DATA    = 8'h00;
        RX_VALID   = 1'b0;
        CMD_READY  = 1'b1;
        idle(3);
        chk("reset_valid", 64'(CMD_VALID), 64'd0);
        chk("reset_addr",  64'(CMD_ADDR),  64'd0);
        chk("reset_wdata", 64'(CMD_WDATA), 64'd0);
        chk("reset_flags", 64'({CMD_RD, ERR_FRAME, ERR_TIMEOUT, ERR_OVERRUN, BUSY}), 64'd0);
        SYS_RST_N = 1'b1;
        idle(2);

        // 1: write frame
        exp_q.push_back('{1'b0, 32'hAABBCCDD, 32'h11223344});
        send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA5);
        idle(3);
        check_errs("t1");

        // 2: read frame, every byte coincident with a tick (byte wins)
        exp_q.push_back('{1'b1, 32'h12345678, 32'hAABBCCDD});
        send_frame(8'h5B, 32'h12345678, 32'hAABBCCDD, 8'hA4, 1'b1);
        idle(3);
        check_errs("t2");

        // 3: junk before a frame
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h33);
        chk("t3_busy_after_junk", 64'(BUSY), 64'd0);
        exp_q.push_back('{1'b0, 32'hAABBCCDD, 32'h11223344});
        send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA5);
        idle(3);
        check_errs("t3");

        // 4: bad trailer
        send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA6);
        e_frame++;
        idle(3);
        check_errs("t4");
        chk("t4_busy", 64'(BUSY), 64'd0);

        // 5: timeout after partial frame; limit is 4 ticks
        send_byte(8'h5A);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (3) do_tick();
        chk("t5_busy_3ticks", 64'(BUSY), 64'd1);
        chk("t5_no_to_3ticks", 64'(n_to), 64'd0);
        do_tick();
        e_to++;
        idle(2);
        check_errs("t5");
        chk("t5_busy_after", 64'(BUSY), 64'd0);
        exp_q.push_back('{1'b0, 32'hAABBCCDD, 32'h11223344});
        send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA5);
        idle(3);
        check_errs("t5b");

        // 6: overrun while output held, then drain
        CMD_READY = 1'b0;
        exp_q.push_back('{1'b0, 32'hAABBCCDD, 32'h11223344});
        send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA5);
        idle(2);
        chk("t6_valid_held", 64'(CMD_VALID), 64'd1);
        send_frame(8'h5B, 32'h12345678, 32'hAABBCCDD, 8'hA4);
        e_ovr++;
        idle(2);
        chk("t6_hold_rd",    64'(CMD_RD),    64'd0);
        chk("t6_hold_addr",  64'(CMD_ADDR),  64'hAABBCCDD);
        chk("t6_hold_wdata", 64'(CMD_WDATA), 64'h11223344);
        chk("t6_ovr_count",  64'(n_ovr),     64'(e_ovr));
        CMD_READY = 1'b1;
        idle(1);
        chk("t6_valid_cleared", 64'(CMD_VALID), 64'd0);
        idle(2);
        check_errs("t6");

        // 6b: reset mid-frame with a held command
        CMD_READY = 1'b0;
        send_frame(8'h5A, 32'hAABBCCDD, 32'h11223344, 8'hA5);
        idle(2);
        send_byte(8'h5B);
        send_byte(8'h12);
        chk("t6b_busy_mid", 64'(BUSY), 64'd1);
        #2;
        SYS_RST_N = 1'b0;
        #1;
        chk("t6b_rst_valid", 64'(CMD_VALID), 64'd0);
        chk("t6b_rst_addr",  64'(CMD_ADDR),  64'd0);
        chk("t6b_rst_wdata", 64'(CMD_WDATA), 64'd0);
        chk("t6b_rst_flags", 64'({CMD_RD, ERR_FRAME, ERR_TIMEOUT, ERR_OVERRUN, BUSY}), 64'd0);
        idle(2);
        SYS_RST_N = 1'b1;
        CMD_READY = 1'b1;
        idle(4);
        check_errs("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
